// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus bundle (imem, decode handshake, redirect, status)
//
// Signals (named from the fetch sequencer's side):
//   imem_addr      out  ADDR_W  instruction memory address (copy of pc)
//   imem_data      in   16      instruction word for imem_addr
//   inst_out       out  16      FIFO head instruction, 0 when empty
//   inst_pc        out  ADDR_W  PC of head instruction, 0 when empty
//   inst_valid     out  1       FIFO non-empty
//   inst_ready     in   1       decode accepts head
//   stall          in   1       suppress new fetches
//   redirect_valid in   1       branch/jump taken
//   redirect_pc    in   ADDR_W  redirect target
//   fault          out  1       sticky fault flag
//   pc             out  ADDR_W  current fetch PC
// Modports: slave = fetch sequencer, master = memory/decode/branch side.

interface fetch_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic [15:0]       inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fault;
  logic [ADDR_W-1:0] pc;

  modport slave (
    output imem_addr,
    input  imem_data,
    output inst_out,
    output inst_pc,
    output inst_valid,
    input  inst_ready,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output fault,
    output pc
  );

  modport master (
    input  imem_addr,
    output imem_data,
    input  inst_out,
    input  inst_pc,
    input  inst_valid,
    output inst_ready,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  fault,
    input  pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with PC, prefetch FIFO, redirect and fault halt
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_sequencer_if.slave: imem_addr/imem_data memory port,
//          inst_out/inst_pc/inst_valid/inst_ready decode handshake,
//          stall, redirect_valid/redirect_pc, fault and pc status.

module fetch_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                MEM_BYTES = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_sequencer_if.slave      bus
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(MEM_BYTES - 2);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              fault_q;

  logic [15:0]       fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic fifo_valid;
  logic pc_legal;
  logic pop;
  logic push;

  function automatic logic is_legal(input logic [ADDR_W-1:0] addr);
    return (addr[0] == 1'b0) && (addr <= LAST_PC);
  endfunction

  assign fifo_valid = (count != '0);
  assign pc_legal   = is_legal(pc_q);
  assign pop        = fifo_valid & bus.inst_ready;
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign push       = (state == S_RUN) & ~bus.stall & ~bus.redirect_valid & pc_legal &
                      ((count < FULL_COUNT) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: flush (a same-cycle pop is dropped with it)
      // and either resume or halt depending on the target.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_q   <= bus.redirect_pc;
      if (is_legal(bus.redirect_pc)) begin
        state   <= S_RUN;
        fault_q <= 1'b0;
      end else begin
        state   <= S_HALT;
        fault_q <= 1'b1;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

      case (state)
        S_RUN: begin
          // Legality is checked before stall so a stalled illegal pc still faults.
          if (!pc_legal) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_data;
            fifo_pc[wr_ptr]   <= pc_q;
            wr_ptr            <= wr_ptr + PTR_W'(1);
            pc_q              <= pc_q + ADDR_W'(2);
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.fault      = fault_q;
  assign bus.inst_valid = fifo_valid;
  assign bus.inst_out   = fifo_valid ? fifo_inst[rd_ptr] : 16'h0000;
  assign bus.inst_pc    = fifo_valid ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a queue-based reference model

module tb_fetch_sequencer;

  localparam int ADDR_W    = 16;
  localparam int MEM_BYTES = 256;
  localparam int DEPTH     = 2;

  logic clk = 1'b0;
  logic rst_n;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(
    .ADDR_W(ADDR_W),
    .MEM_BYTES(MEM_BYTES),
    .RESET_PC(16'h0000),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory with combinational read.
  logic [7:0] mem [MEM_BYTES];
  assign bus.imem_data = (bus.imem_addr < 16'd255) ?
                         {mem[bus.imem_addr[7:0]], mem[bus.imem_addr[7:0] + 8'd1]} : 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of {inst, pc} entries, a pc and a fault flag.
  // The sequencer is halted exactly when fault is set.
  logic [31:0]       m_q [$];
  logic [ADDR_W-1:0] m_pc;
  logic              m_fault;

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return (a % 2 == 0) && (int'(a) <= MEM_BYTES - 2);
  endfunction

  function automatic logic [15:0] word_at(input logic [ADDR_W-1:0] a);
    if (int'(a) + 1 < MEM_BYTES) return {mem[int'(a)], mem[int'(a) + 1]};
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc    = 16'h0000;
    m_fault = 1'b0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs currently driven.
  task automatic model_edge();
    bit do_pop;
    do_pop = (m_q.size() > 0) && bus.inst_ready;
    if (bus.redirect_valid) begin
      m_q.delete();
      m_pc    = bus.redirect_pc;
      m_fault = !legal(bus.redirect_pc);
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (!m_fault) begin
        if (!legal(m_pc)) begin
          m_fault = 1'b1;
        end else if (!bus.stall && m_q.size() < DEPTH) begin
          m_q.push_back({word_at(m_pc), m_pc});
          m_pc = m_pc + 16'd2;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0]       e_inst;
    logic [ADDR_W-1:0] e_ipc;
    e_inst = (m_q.size() > 0) ? m_q[0][31:16] : 16'h0000;
    e_ipc  = (m_q.size() > 0) ? m_q[0][15:0]  : 16'h0000;
    check({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(m_q.size() > 0));
    check({tag, ".inst_out"},   32'(bus.inst_out),   32'(e_inst));
    check({tag, ".inst_pc"},    32'(bus.inst_pc),    32'(e_ipc));
    check({tag, ".pc"},         32'(bus.pc),         32'(m_pc));
    check({tag, ".imem_addr"},  32'(bus.imem_addr),  32'(m_pc));
    check({tag, ".fault"},      32'(bus.fault),      32'(m_fault));
  endtask

  // Inputs are driven at the falling edge; one call = one rising edge then checks.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic rv, input logic [ADDR_W-1:0] rpc);
    bus.inst_ready     = rdy;
    bus.stall          = stl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  // Asynchronous reset between edges, checked before the next rising edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    mem[0] = 8'hE0; mem[1] = 8'h00; mem[2] = 8'h72; mem[3] = 8'h59;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Sequential fetch with decode always ready.
    step("seq1");
    check("seq1.const_inst", 32'(bus.inst_out), 32'h0000_E000);
    step("seq2");
    check("seq2.const_inst", 32'(bus.inst_out), 32'h0000_7259);
    check("seq2.const_ipc",  32'(bus.inst_pc),  32'h0000_0002);
    for (int i = 0; i < 4; i++) step("seq_run");

    // Mid-stream asynchronous reset, then back-pressure from decode.
    async_reset("async_rst");
    check("async_rst.const_pc", 32'(bus.pc), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step("bp_fill");
    check("bp.const_pc",   32'(bus.pc),       32'h4);
    check("bp.const_inst", 32'(bus.inst_out), 32'hE000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) step("bp_drain");

    // Redirect flush while FIFO holds pc0 and pc2; a same-cycle pop is discarded.
    async_reset("rst2");
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step("rd_fill1");
    step("rd_fill2");
    drive(1'b1, 1'b0, 1'b1, 16'h0002);
    step("rd_flush");
    check("rd_flush.const_valid", 32'(bus.inst_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step("rd_after");
    check("rd_after.const_inst", 32'(bus.inst_out), 32'h7259);

    // Run to the end of memory and fault, then drain.
    drive(1'b1, 1'b0, 1'b1, 16'h00F0);
    step("end_redirect");
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 12; i++) step("end_run");
    check("end.const_fault", 32'(bus.fault), 32'h1);
    check("end.const_pc",    32'(bus.pc),    32'h100);

    // Misaligned redirect halts, legal redirect recovers.
    drive(1'b1, 1'b0, 1'b1, 16'h0003);
    step("odd_redirect");
    check("odd.const_fault", 32'(bus.fault), 32'h1);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    step("recover_redirect");
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    step("recover_fetch");
    check("recover.const_inst", 32'(bus.inst_out), 32'hE000);

    // Stall does not mask the fault check.
    drive(1'b0, 1'b0, 1'b1, 16'h00FE);
    step("stall_redirect");
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    step("stall_push_fe");
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    step("stall_fault");
    check("stall.const_fault", 32'(bus.fault), 32'h1);

    // Randomized phase against the model.
    for (int i = 4; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    step("rnd_start");
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] rpc;
      int sel;
      sel = $urandom_range(0, 2);
      if (sel == 0)      rpc = 16'($urandom_range(0, 127) * 2);
      else if (sel == 1) rpc = 16'($urandom_range(0, 127) * 2 + 1);
      else               rpc = 16'($urandom_range(256, 65535));
      if (sel != 0 && $urandom_range(0, 3) != 0) rpc = 16'($urandom_range(0, 127) * 2);
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
            1'($urandom_range(0, 19) == 0), rpc);
      if (n % 97 == 96) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
